// File: rtl/ame_pkg.sv
// Shared state encoding, matrix dimensions and coefficient slot mapping for the
// affine normal-equation builder.
package ame_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_DONE} state_t;

    localparam int MAT_ROWS     = 6;
    localparam int MAT_COLS     = 7;
    localparam int COL_B        = MAT_COLS - 1;
    localparam int NUM_MAC      = 27;
    localparam int DRAIN_CYCLES = 3;

    // 6-parameter coefficient slots
    localparam int P6_GX  = 0;
    localparam int P6_XGX = 1;
    localparam int P6_GY  = 2;
    localparam int P6_XGY = 3;
    localparam int P6_YGX = 4;
    localparam int P6_YGY = 5;

    // 4-parameter coefficient slots; slots 0 and 1 stay zero
    localparam int P4_GX  = 2;
    localparam int P4_SCL = 3;
    localparam int P4_GY  = 4;
    localparam int P4_ROT = 5;

    // Upper-triangle A entries row-major (0..20), then B entries (21..26).
    function automatic int mac_idx(input int r, input int c);
        if (c == COL_B) return NUM_MAC - MAT_ROWS + r;
        return r * MAT_ROWS - (r * (r - 1)) / 2 + (c - r);
    endfunction

    function automatic logic [2:0] clamp_log2(input logic [2:0] v);
        return (v < 3'd2) ? 3'd7 : v;
    endfunction

endpackage

// File: rtl/ame_mac_cell.sv
// Registered signed multiply then accumulate with clear; 2-cycle latency, no backpressure.
// AME_BUILDER_SAT_EN selects saturating accumulation with a sticky overflow flag.
module ame_mac_cell #(
    parameter int IN_W  = 25,
    parameter int ACC_W = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clr_i,
    input  logic                    vld_i,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic signed [ACC_W-1:0] acc_o
);

`ifdef AME_BUILDER_SAT_EN
    localparam int PRW = 2 * IN_W;
    localparam int SW  = ((PRW > ACC_W) ? PRW : ACC_W) + 1;
`else
    // Wrapping only needs the low ACC_W bits of the product.
    localparam int PRW = (2 * IN_W < ACC_W) ? 2 * IN_W : ACC_W;
    localparam int SW  = ACC_W;
`endif

    logic signed [PRW-1:0]   a_ext, b_ext, prod_q;
    logic                    prod_vld_q;
    logic signed [SW-1:0]    sum;
    logic signed [ACC_W-1:0] acc_next;

    assign a_ext = PRW'(a_i);
    assign b_ext = PRW'(b_i);
    assign sum   = SW'(acc_o) + SW'(prod_q);

`ifdef AME_BUILDER_SAT_EN
    logic sum_fits;
    logic ovf_q;

    assign sum_fits = (&sum[SW-1:ACC_W-1]) | ~(|sum[SW-1:ACC_W-1]);

    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (!sum_fits) begin
            acc_next = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            ovf_q <= 1'b0;
        end else if (prod_vld_q && !sum_fits) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_o      <= '0;
        end else if (clr_i) begin
            prod_vld_q <= 1'b0;
            acc_o      <= '0;
        end else begin
            prod_vld_q <= vld_i;
            if (vld_i) prod_q <= a_ext * b_ext;
            if (prod_vld_q) acc_o <= acc_next;
        end
    end

endmodule

// File: rtl/ame_equation_builder.sv
// Accumulates the 6x7 affine normal equations from a raster sample stream; done 4 cycles after last accept.
// Ready only while accumulating (no stall mid-block); AME_BUILDER_SAT_EN enables saturating accumulators.
module ame_equation_builder
    import ame_pkg::*;
#(
    parameter int COMP_DATA_BITS = 64,
    parameter int SAMP_DATA_BITS = 16,
    parameter int BLK_SIZE_BITS  = 7
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             comp_init_i,
    output logic                             comp_done_o,
    input  logic                             affine_param6_i,
    input  logic [2:0]                       blk_width_log2_i,
    input  logic [2:0]                       blk_height_log2_i,
    input  logic                             samp_valid_i,
    output logic                             samp_ready_o,
    input  logic signed [SAMP_DATA_BITS-1:0] samp_grad_x_i,
    input  logic signed [SAMP_DATA_BITS-1:0] samp_grad_y_i,
    input  logic signed [SAMP_DATA_BITS-1:0] samp_diff_i,
    output logic [MAT_ROWS-1:0][MAT_COLS-1:0][COMP_DATA_BITS-1:0] comp_data_o
);

    localparam int CW = SAMP_DATA_BITS + BLK_SIZE_BITS + 2;

    state_t                   state_q;
    logic [1:0]               drain_cnt_q;
    logic                     mode6_q;
    logic [2:0]               wlog2_q, hlog2_q;
    logic [BLK_SIZE_BITS-1:0] x_q, y_q, x_last, y_last;
    logic                     accept;

    assign accept = samp_valid_i & samp_ready_o & ~comp_init_i;
    assign x_last = ~({BLK_SIZE_BITS{1'b1}} << wlog2_q);
    assign y_last = ~({BLK_SIZE_BITS{1'b1}} << hlog2_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            samp_ready_o <= 1'b0;
            comp_done_o  <= 1'b0;
            drain_cnt_q  <= '0;
            mode6_q      <= 1'b0;
            wlog2_q      <= '0;
            hlog2_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            comp_done_o <= 1'b0;
            if (comp_init_i) begin
                state_q      <= ST_ACCUM;
                samp_ready_o <= 1'b1;
                drain_cnt_q  <= '0;
                mode6_q      <= affine_param6_i;
                wlog2_q      <= clamp_log2(blk_width_log2_i);
                hlog2_q      <= clamp_log2(blk_height_log2_i);
                x_q          <= '0;
                y_q          <= '0;
            end else begin
                case (state_q)
                    ST_ACCUM: begin
                        if (accept) begin
                            if (x_q == x_last) begin
                                x_q <= '0;
                                if (y_q == y_last) begin
                                    state_q      <= ST_DRAIN;
                                    samp_ready_o <= 1'b0;
                                    drain_cnt_q  <= '0;
                                end else begin
                                    y_q <= y_q + 1'b1;
                                end
                            end else begin
                                x_q <= x_q + 1'b1;
                            end
                        end
                    end
                    // Wait for the last sample to clear the coefficient and product stages.
                    ST_DRAIN: begin
                        if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
                            state_q     <= ST_DONE;
                            comp_done_o <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 2'd1;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Operand vector: coefficients c0..c5 in slots 0..5, residual in slot 6.
    logic signed [CW-1:0] gx, gy, xs, ys;
    logic signed [CW-1:0] opnd_d [MAT_COLS];
    logic signed [CW-1:0] opnd_q [MAT_COLS];
    logic                 opnd_vld_q;

    assign gx = CW'(samp_grad_x_i);
    assign gy = CW'(samp_grad_y_i);
    assign xs = CW'({1'b0, x_q});
    assign ys = CW'({1'b0, y_q});

    always_comb begin
        for (int k = 0; k < MAT_COLS; k++) opnd_d[k] = '0;
        opnd_d[COL_B] = CW'(samp_diff_i);
        if (mode6_q) begin
            opnd_d[P6_GX]  = gx;
            opnd_d[P6_XGX] = xs * gx;
            opnd_d[P6_GY]  = gy;
            opnd_d[P6_XGY] = xs * gy;
            opnd_d[P6_YGX] = ys * gx;
            opnd_d[P6_YGY] = ys * gy;
        end else begin
            opnd_d[P4_GX]  = gx;
            opnd_d[P4_SCL] = xs * gx + ys * gy;
            opnd_d[P4_GY]  = gy;
            opnd_d[P4_ROT] = xs * gy - ys * gx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            opnd_vld_q <= 1'b0;
            opnd_q     <= '{default: '0};
        end else begin
            opnd_vld_q <= accept;
            if (accept) opnd_q <= opnd_d;
        end
    end

    logic [COMP_DATA_BITS-1:0] acc [NUM_MAC];

    for (genvar r = 0; r < MAT_ROWS; r++) begin : g_row
        for (genvar c = r; c < MAT_COLS; c++) begin : g_col
            localparam int IDX = mac_idx(r, c);
            ame_mac_cell #(
                .IN_W  (CW),
                .ACC_W (COMP_DATA_BITS)
            ) u_mac (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .clr_i   (comp_init_i),
                .vld_i   (opnd_vld_q),
                .a_i     (opnd_q[r]),
                .b_i     (opnd_q[c]),
                .acc_o   (acc[IDX])
            );
        end
    end

    // Lower triangle of A mirrors the upper triangle.
    for (genvar r = 0; r < MAT_ROWS; r++) begin : g_out_r
        for (genvar c = 0; c < MAT_COLS; c++) begin : g_out_c
            if (c >= r) begin : g_up
                localparam int IDX = mac_idx(r, c);
                assign comp_data_o[r][c] = acc[IDX];
            end else begin : g_lo
                localparam int IDX = mac_idx(c, r);
                assign comp_data_o[r][c] = acc[IDX];
            end
        end
    end

endmodule

// File: tb/tb_ame_equation_builder.sv
// Randomized bench for ame_equation_builder against a plain-arithmetic normal-equation model.
module tb_ame_equation_builder;

    localparam int CDB = 32;
    localparam int SDB = 16;
    localparam int BSB = 7;

    logic                           clk = 1'b0;
    logic                           rst_n_i;
    logic                           comp_init_i;
    logic                           comp_done_o;
    logic                           affine_param6_i;
    logic [2:0]                     blk_width_log2_i;
    logic [2:0]                     blk_height_log2_i;
    logic                           samp_valid_i;
    logic                           samp_ready_o;
    logic [SDB-1:0]                 samp_grad_x_i;
    logic [SDB-1:0]                 samp_grad_y_i;
    logic [SDB-1:0]                 samp_diff_i;
    logic [5:0][6:0][CDB-1:0]       comp_data_o;

    ame_equation_builder #(
        .COMP_DATA_BITS (CDB),
        .SAMP_DATA_BITS (SDB),
        .BLK_SIZE_BITS  (BSB)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n_i),
        .comp_init_i       (comp_init_i),
        .comp_done_o       (comp_done_o),
        .affine_param6_i   (affine_param6_i),
        .blk_width_log2_i  (blk_width_log2_i),
        .blk_height_log2_i (blk_height_log2_i),
        .samp_valid_i      (samp_valid_i),
        .samp_ready_o      (samp_ready_o),
        .samp_grad_x_i     (samp_grad_x_i),
        .samp_grad_y_i     (samp_grad_y_i),
        .samp_diff_i       (samp_diff_i),
        .comp_data_o       (comp_data_o)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_pass = 0;
    int     done_cnt = 0;
    int     q_gx[$], q_gy[$], q_df[$];
    longint exp_m [6][7];

    always @(negedge clk) if (comp_done_o) done_cnt = done_cnt + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint trunc(input longint v);
        return (v <<< (64 - CDB)) >>> (64 - CDB);
    endfunction

    function automatic longint elem(input int i, input int j);
        return longint'($signed(comp_data_o[i][j]));
    endfunction

    function automatic int side(input int l2);
        return (l2 < 2) ? 128 : (1 << l2);
    endfunction

    task automatic fill_const(input int n, input int gx, input int gy, input int df);
        q_gx.delete(); q_gy.delete(); q_df.delete();
        for (int k = 0; k < n; k++) begin
            q_gx.push_back(gx); q_gy.push_back(gy); q_df.push_back(df);
        end
    endtask

    task automatic fill_rand(input int n, input int rng);
        q_gx.delete(); q_gy.delete(); q_df.delete();
        for (int k = 0; k < n; k++) begin
            q_gx.push_back(int'($urandom_range(2 * rng)) - rng);
            q_gy.push_back(int'($urandom_range(2 * rng)) - rng);
            q_df.push_back(int'($urandom_range(2 * rng)) - rng);
        end
    endtask

    // Normal equations straight from the definition: sum over samples of c*c^T and c*diff.
    task automatic build_model(input bit p6, input int w);
        longint c [7];
        longint x, y, gx, gy;
        for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) exp_m[i][j] = 0;
        for (int k = 0; k < q_gx.size(); k++) begin
            x = k % w; y = k / w; gx = q_gx[k]; gy = q_gy[k];
            if (p6) begin
                c[0] = gx; c[1] = x * gx; c[2] = gy; c[3] = x * gy; c[4] = y * gx; c[5] = y * gy;
            end else begin
                c[0] = 0; c[1] = 0; c[2] = gx; c[3] = x * gx + y * gy; c[4] = gy; c[5] = x * gy - y * gx;
            end
            c[6] = q_df[k];
            for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) exp_m[i][j] += c[i] * c[j];
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                check($sformatf("%s m[%0d][%0d]", tag, i, j), elem(i, j), trunc(exp_m[i][j]));
    endtask

    // Called at a negedge; a junk sample is offered alongside init and must be ignored.
    task automatic do_init(input bit p6, input int wl, input int hl);
        comp_init_i       = 1'b1;
        affine_param6_i   = p6;
        blk_width_log2_i  = 3'(wl);
        blk_height_log2_i = 3'(hl);
        samp_valid_i      = 1'b1;
        samp_grad_x_i     = SDB'($urandom);
        samp_grad_y_i     = SDB'($urandom);
        samp_diff_i       = SDB'($urandom);
        @(negedge clk);
        comp_init_i  = 1'b0;
        samp_valid_i = 1'b0;
        check("ready_after_init", samp_ready_o, 1);
    endtask

    task automatic stream(input int n, input int gap);
        int k, cyc;
        bit v, ok;
        k = 0; cyc = 0;
        while (k < n && cyc < 4 * n + 200) begin
            v = ($urandom_range(99) >= gap);
            samp_valid_i  = v;
            samp_grad_x_i = SDB'(q_gx[k]);
            samp_grad_y_i = SDB'(q_gy[k]);
            samp_diff_i   = SDB'(q_df[k]);
            ok = v && samp_ready_o;
            @(negedge clk);
            if (ok) k++;
            cyc++;
        end
        samp_valid_i = 1'b0;
        check("stream_accepts", k, n);
    endtask

    // Entered at the first negedge after the final accept edge; done belongs in the fourth.
    task automatic wait_done(input string tag);
        int lat, pulses;
        lat = -1; pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (comp_done_o) begin
                if (lat < 0) lat = c;
                pulses++;
            end
        end
        check({tag, " done_latency"}, lat, 4);
        check({tag, " done_width"}, pulses, 1);
    endtask

    task automatic run_block(input string tag, input bit p6, input int wl, input int hl, input int gap);
        int d0;
        do_init(p6, wl, hl);
        d0 = done_cnt;
        stream(q_gx.size(), gap);
        wait_done(tag);
        check({tag, " done_pulses"}, done_cnt - d0, 1);
        build_model(p6, side(wl));
        compare_all(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int     d_pre, wl, hl;
        longint big;
        rst_n_i = 1'b0; comp_init_i = 1'b0; affine_param6_i = 1'b0;
        blk_width_log2_i = '0; blk_height_log2_i = '0; samp_valid_i = 1'b0;
        samp_grad_x_i = '0; samp_grad_y_i = '0; samp_diff_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", samp_ready_o, 0);
        check("rst_done", comp_done_o, 0);
        check("rst_data", longint'(|comp_data_o), 0);
        rst_n_i = 1'b1;
        @(negedge clk);
        check("idle_ready", samp_ready_o, 0);

        fill_const(16, 1, 0, 2);
        run_block("p6_ramp", 1'b1, 2, 2, 0);
        check("p6 A00", elem(0, 0), 16);
        check("p6 A10", elem(1, 0), 24);
        check("p6 A11", elem(1, 1), 56);
        check("p6 A41", elem(4, 1), 36);
        check("p6 A44", elem(4, 4), 56);
        check("p6 B1", elem(1, 6), 48);

        fill_const(16, 0, 1, -1);
        run_block("p4_ramp", 1'b0, 2, 2, 0);
        check("p4 A33", elem(3, 3), 56);
        check("p4 A44", elem(4, 4), 16);
        check("p4 A53", elem(5, 3), 36);
        check("p4 A45", elem(4, 5), 24);
        check("p4 B3", elem(3, 6), -24);
        check("p4 B4", elem(4, 6), -16);

        fill_const(16, 1, 0, 2);
        run_block("p6_gaps", 1'b1, 2, 2, 45);
        check("gaps A00", elem(0, 0), 16);
        check("gaps B4", elem(4, 6), 48);

        for (int t = 0; t < 6; t++) begin
            wl = 2 + t % 2;
            hl = 2 + (t / 2) % 2;
            fill_rand(side(wl) * side(hl), 255);
            run_block($sformatf("rand%0d", t), 1'($urandom_range(1)), wl, hl, int'($urandom_range(50)));
        end

        fill_rand(128 * 4, 3);
        run_block("clamp_w", 1'b1, 0, 2, 10);
        fill_rand(4 * 128, 3);
        run_block("clamp_h", 1'b0, 2, 1, 10);

        d_pre = done_cnt;
        fill_rand(7, 255);
        do_init(1'b1, 2, 2);
        stream(7, 20);
        fill_rand(16, 255);
        run_block("restart", 1'b1, 2, 2, 20);
        check("restart_total_done", done_cnt - d_pre, 1);

        fill_const(16, 1, 0, 2);
        do_init(1'b1, 2, 2);
        d_pre = done_cnt;
        stream(16, 0);
        rst_n_i = 1'b0;
        #1;
        check("drain_rst_ready", samp_ready_o, 0);
        check("drain_rst_done", comp_done_o, 0);
        check("drain_rst_data", longint'(|comp_data_o), 0);
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (8) @(negedge clk);
        check("drain_rst_no_done", done_cnt - d_pre, 0);
        fill_rand(16, 255);
        run_block("after_rst", 1'b0, 2, 2, 10);

        fill_const(128 * 128, 32767, 0, 0);
        do_init(1'b1, 7, 7);
        stream(128 * 128, 0);
        wait_done("big");
        big = 16384;
        big = big * 32767 * 32767;
`ifdef AME_BUILDER_SAT_EN
        check("big A00 sat", elem(0, 0), 64'sd2147483647);
        check("big A00 ovf", longint'(dut.g_row[0].g_col[0].u_mac.ovf_q), 1);
        check("big A22 ovf", longint'(dut.g_row[2].g_col[2].u_mac.ovf_q), 0);
`else
        check("big A00 wrap", elem(0, 0), trunc(big));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
